// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module apb_rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int unsigned   k;
  logic [IW-1:0] kk;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      k  = (32'(last) + off) % N;
      kk = IW'(k);
      if (!found && req[kk]) begin
        gnt[kk] = 1'b1;
        idx     = kk;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// with per-requester completion pulses and an ACCESS-phase timeout.
module apb_master_arbiter
  import apb_arb_pkg::apb_arb_state_e, apb_arb_pkg::IDLE,
         apb_arb_pkg::SETUP, apb_arb_pkg::ACCESS;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = apb_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W  = apb_arb_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_arb_state_e     state, state_nxt;
  logic [IW-1:0]      last, last_nxt, win, win_nxt, pick_idx;
  logic [TW-1:0]      cnt, cnt_nxt;
  logic [NUM_REQ-1:0] pick_gnt, gnt_nxt, done_nxt;
  logic               err_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0]  paddr_nxt;
  logic [DATA_W-1:0]  pwdata_nxt, rdata_nxt;
  logic               timeout_hit;

  apb_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_i),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // Last allowed wait cycle without pready; unreachable when TIMEOUT is 0.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state     <= IDLE;
      last      <= IW'(NUM_REQ - 1);
      win       <= '0;
      cnt       <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      win       <= win_nxt;
      cnt       <= cnt_nxt;
      gnt_o     <= gnt_nxt;
      done_o    <= done_nxt;
      err_o     <= err_nxt;
      rdata_o   <= rdata_nxt;
      psel_o    <= psel_nxt;
      penable_o <= penable_nxt;
      pwrite_o  <= pwrite_nxt;
      paddr_o   <= paddr_nxt;
      pwdata_o  <= pwdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    win_nxt     = win;
    cnt_nxt     = cnt;
    gnt_nxt     = '0;
    done_nxt    = '0;
    err_nxt     = 1'b0;
    rdata_nxt   = rdata_o;
    psel_nxt    = psel_o;
    penable_nxt = penable_o;
    pwrite_nxt  = pwrite_o;
    paddr_nxt   = paddr_o;
    pwdata_nxt  = pwdata_o;
    case (state)
      IDLE: begin
        if (|req_i) begin
          state_nxt   = SETUP;
          last_nxt    = pick_idx;
          win_nxt     = pick_idx;
          gnt_nxt     = pick_gnt;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          pwrite_nxt  = req_write_i[pick_idx];
          paddr_nxt   = req_addr_i[32'(pick_idx) * ADDR_W +: ADDR_W];
          pwdata_nxt  = req_wdata_i[32'(pick_idx) * DATA_W +: DATA_W];
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: begin
        if (pready_i || timeout_hit) begin
          state_nxt     = IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          done_nxt[win] = 1'b1;
          err_nxt       = !pready_i;
          if (!pwrite_o) rdata_nxt = pready_i ? prdata_i : '0;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scenario bench for apb_master_arbiter against a one-wait-state APB slave model.
module tb_apb_master_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [N-1:0]  done;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic            pclk = 1'b0;
  logic            preset_n;
  logic [N-1:0]    req_i, req_write_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    gnt_o, done_o;
  logic            err_o, psel_o, penable_o, pwrite_o;
  logic [DW-1:0]   rdata_o, pwdata_o;
  logic [AW-1:0]   paddr_o;
  logic [DW-1:0]   prdata_i = '0;
  logic            pready_i = 1'b0;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   acc    = 0;
  bit   slave_en = 1'b1;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset_n(preset_n), .req_i(req_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  // Slave: ready in the second ACCESS cycle, read data = address + 0x0A.
  always @(negedge pclk) begin
    if (psel_o && penable_o) acc = acc + 1;
    else acc = 0;
    pready_i = slave_en && (acc >= 2);
    prdata_i = paddr_o + 32'h0A;
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (gnt_o !== '0) return;
    end
    checks++; fails++;
    $display("FAIL %s_gnt_wait: gnt_o=%b after 50 cycles, required a grant", tag, gnt_o);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int i = 0;
    while (done_o === '0 && i < 50) begin
      @(negedge pclk);
      i++;
    end
    if (done_o === '0) begin
      checks++; fails++;
      $display("FAIL %s_done_wait: no done_o after 50 cycles", tag);
      return;
    end
    if (sb.size() == 0) begin
      checks++; fails++;
      $display("FAIL %s_done_unexpected: done_o=%b with nothing outstanding", tag, done_o);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (done_o !== e.done) begin
      fails++; $display("FAIL %s_done: got %b required %b", tag, done_o, e.done);
    end
    checks++;
    if (err_o !== e.err) begin
      fails++; $display("FAIL %s_err: got %b required %b", tag, err_o, e.err);
    end
    checks++;
    if (rdata_o !== e.rdata) begin
      fails++; $display("FAIL %s_rdata: got %h required %h", tag, rdata_o, e.rdata);
    end
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    req_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
    repeat (2) tick();
    checks++;
    if ({gnt_o, done_o, err_o, psel_o, penable_o, pwrite_o} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: gnt=%b done=%b err=%b psel=%b pen=%b pwr=%b required all 0",
               gnt_o, done_o, err_o, psel_o, penable_o, pwrite_o);
    end
    checks++;
    if ({paddr_o, pwdata_o, rdata_o} !== '0) begin
      fails++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h required 0", paddr_o, pwdata_o, rdata_o);
    end
    preset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (psel_o !== 1'b0) begin
        fails++; $display("FAIL reset_idle_psel: got %b required 0", psel_o);
      end
    end
  endtask

  task automatic test_single_read();
    int g;
    req_addr_i[1*AW +: AW] = 32'h10;
    req_write_i[1] = 1'b0;
    sb.push_back({4'b0010, 1'b0, 32'h1A});
    req_i[1] = 1'b1;
    wait_gnt("read");
    g = cyc;
    checks++;
    if (gnt_o !== 4'b0010) begin
      fails++; $display("FAIL read_gnt: got %b required 0010", gnt_o);
    end
    checks++;
    if (psel_o !== 1'b1 || penable_o !== 1'b0) begin
      fails++; $display("FAIL read_setup: psel=%b pen=%b required 1 0", psel_o, penable_o);
    end
    checks++;
    if (paddr_o !== 32'h10 || pwrite_o !== 1'b0) begin
      fails++; $display("FAIL read_cmd: paddr=%h pwrite=%b required 10 0", paddr_o, pwrite_o);
    end
    req_i[1] = 1'b0;
    tick();
    checks++;
    if (psel_o !== 1'b1 || penable_o !== 1'b1 || gnt_o !== '0) begin
      fails++;
      $display("FAIL read_access: psel=%b pen=%b gnt=%b required 1 1 0000", psel_o, penable_o, gnt_o);
    end
    wait_done("read");
    checks++;
    if (cyc - g !== 3) begin
      fails++; $display("FAIL read_latency: got %0d cycles required 3", cyc - g);
    end
  endtask

  task automatic test_single_write();
    req_addr_i[2*AW +: AW]  = 32'h20;
    req_wdata_i[2*DW +: DW] = 32'hDEADBEEF;
    req_write_i[2] = 1'b1;
    sb.push_back({4'b0100, 1'b0, 32'h1A});
    req_i[2] = 1'b1;
    wait_gnt("write");
    checks++;
    if (gnt_o !== 4'b0100 || pwrite_o !== 1'b1 || pwdata_o !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_setup: gnt=%b pwrite=%b pwdata=%h required 0100 1 deadbeef",
               gnt_o, pwrite_o, pwdata_o);
    end
    req_i[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (!(psel_o && penable_o) || pwdata_o !== 32'hDEADBEEF || pwrite_o !== 1'b1 || paddr_o !== 32'h20) begin
        fails++;
        $display("FAIL write_stable: psel=%b pen=%b pwdata=%h pwrite=%b paddr=%h required 1 1 deadbeef 1 20",
                 psel_o, penable_o, pwdata_o, pwrite_o, paddr_o);
      end
    end
    wait_done("write");
    checks++;
    if (pwdata_o !== 32'hDEADBEEF || paddr_o !== 32'h20 || psel_o !== 1'b0) begin
      fails++;
      $display("FAIL write_idle_hold: pwdata=%h paddr=%h psel=%b required deadbeef 20 0",
               pwdata_o, paddr_o, psel_o);
    end
  endtask

  task automatic test_contention();
    int prev = 0;
    int k;
    logic [N-1:0] oh;
    preset_n = 1'b0;
    req_i = '0;
    repeat (2) tick();
    preset_n = 1'b1;
    tick();
    for (int i = 0; i < int'(N); i++) begin
      req_addr_i[i*AW +: AW] = 32'h100 + 32'(i * 16);
      req_write_i[i] = 1'b0;
    end
    req_i = '1;
    for (int n = 0; n < 5; n++) begin
      k  = n % int'(N);
      oh = '0;
      oh[k] = 1'b1;
      wait_gnt("cont");
      checks++;
      if (!$onehot(gnt_o) || gnt_o !== oh) begin
        fails++; $display("FAIL cont_order%0d: got %b required %b", n, gnt_o, oh);
      end
      if (n > 0) begin
        checks++;
        if (cyc - prev !== 4) begin
          fails++; $display("FAIL cont_period%0d: got %0d cycles required 4", n, cyc - prev);
        end
      end
      prev = cyc;
      sb.push_back({oh, 1'b0, 32'h100 + 32'(k * 16) + 32'h0A});
      req_i = req_i & ~gnt_o;
      wait_done("cont");
      if (n < 4) req_i = req_i | done_o;
    end
    req_i = '0;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    slave_en = 1'b0;
    req_addr_i[0 +: AW] = 32'h40;
    req_write_i[0] = 1'b0;
    sb.push_back({4'b0001, 1'b1, 32'h0});
    req_i[0] = 1'b1;
    wait_gnt("tmo");
    checks++;
    if (gnt_o !== 4'b0001) begin
      fails++; $display("FAIL tmo_gnt: got %b required 0001", gnt_o);
    end
    req_i[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o !== '0) break;
      if (psel_o && penable_o) n++;
    end
    checks++;
    if (n !== 16) begin
      fails++; $display("FAIL tmo_cycles: got %0d ACCESS cycles required 16", n);
    end
    checks++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
      fails++; $display("FAIL tmo_bus: psel=%b pen=%b required 0 0", psel_o, penable_o);
    end
    wait_done("tmo");
    slave_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    req_addr_i[3*AW +: AW] = 32'h30;
    req_write_i[3] = 1'b0;
    req_i[3] = 1'b1;
    wait_gnt("mrst");
    checks++;
    if (gnt_o !== 4'b1000) begin
      fails++; $display("FAIL mrst_gnt: got %b required 1000", gnt_o);
    end
    req_i[3] = 1'b0;
    tick();
    checks++;
    if (penable_o !== 1'b1) begin
      fails++; $display("FAIL mrst_access: penable=%b required 1", penable_o);
    end
    preset_n = 1'b0;
    #1;
    checks++;
    if (psel_o !== 1'b0 || penable_o !== 1'b0) begin
      fails++; $display("FAIL mrst_drop: psel=%b pen=%b required 0 0", psel_o, penable_o);
    end
    req_i = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done_o !== '0) begin
        fails++; $display("FAIL mrst_nodone: got %b required 0000", done_o);
      end
    end
    preset_n = 1'b1;
    wait_gnt("mrst_r0");
    checks++;
    if (gnt_o !== 4'b0001) begin
      fails++; $display("FAIL mrst_first: got %b required 0001", gnt_o);
    end
    sb.push_back({4'b0001, 1'b0, 32'h4A});
    req_i = req_i & ~gnt_o;
    wait_done("mrst_r0");
    wait_gnt("mrst_r3");
    checks++;
    if (gnt_o !== 4'b1000) begin
      fails++; $display("FAIL mrst_second: got %b required 1000", gnt_o);
    end
    sb.push_back({4'b1000, 1'b0, 32'h3A});
    req_i = req_i & ~gnt_o;
    wait_done("mrst_r3");
    tick();
    checks++;
    if (sb.size() != 0 || done_o !== '0) begin
      fails++; $display("FAIL sb_drain: %0d outstanding, done=%b required 0 0000", sb.size(), done_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port among `NUM_REQ` local requesters. Requesters post single read or write commands. The block arbitrates between them round-robin and runs the APB SETUP/ACCESS sequence on the bus. It returns a per-requester completion pulse with read data, or an error flag on slave timeout. It sits between the command sources and the APB fabric, in front of slaves such as the test slave (one-cycle `pready_i` after `psel_o && penable_o`).

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 32: APB data width.
- `TIMEOUT`, 16: maximum ACCESS cycles without `pready_i` before abort. 0 disables the timeout.

Ports:
- `pclk` in 1: clock; all logic on the rising edge.
- `preset_n` in 1: asynchronous, active-low reset.
- `req_i` in NUM_REQ: per-requester request, held until `gnt_o` bit seen.
- `req_write_i` in NUM_REQ: 1 = write, 0 = read.
- `req_addr_i` in NUM_REQ*ADDR_W: flattened addresses; requester k at `[k*ADDR_W +: ADDR_W]`.
- `req_wdata_i` in NUM_REQ*DATA_W: flattened write data, same packing.
- `gnt_o` out NUM_REQ: one-hot, one-cycle pulse; the command has been captured.
- `done_o` out NUM_REQ: one-hot, one-cycle pulse; the transfer has finished.
- `err_o` out 1: valid with `done_o`; 1 = timeout abort.
- `rdata_o` out DATA_W: read data of the last completed read.
- `psel_o`, `penable_o`, `pwrite_o` out 1: APB controls.
- `paddr_o` out ADDR_W: APB address.
- `pwdata_o` out DATA_W: APB write data.
- `prdata_i` in DATA_W: APB read data.
- `pready_i` in 1: APB ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE**
  - If any `req_i` bit is set, select the winner round-robin. Search starts at `last+1` mod NUM_REQ.
  - Latch the winner's addr, wdata and write into `paddr_o`/`pwdata_o`/`pwrite_o`.
  - Set `last` to the winner and go to SETUP.
  - With no request, stay in IDLE.
- **SETUP**
  - `psel_o`=1, `penable_o`=0.
  - `gnt_o[winner]`=1 for this cycle only.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - `psel_o`=1, `penable_o`=1.
  - If `pready_i`=1: go to IDLE. Next cycle, `done_o[winner]`=1 and `err_o`=0. For a read, capture `prdata_i` into `rdata_o`; for a write, leave `rdata_o` unchanged.
  - Wait counter: cleared on entry to ACCESS, incremented per ACCESS cycle with `pready_i`=0.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT-1` with `pready_i`=0: go to IDLE with `done_o[winner]`=1 and `err_o`=1. A read also sets `rdata_o` to 0.
- `paddr_o`, `pwdata_o` and `pwrite_o` stay stable from SETUP through the end of ACCESS and keep their values in IDLE.
- Counter width is `$clog2(TIMEOUT+1)`.
- A requester deasserts `req_i` on the edge after seeing its `gnt_o`. A still-high `req_i` in a later IDLE is treated as a new command.
- Every transfer returns through IDLE; there is no ACCESS→SETUP shortcut.
- Reset values:
  - All outputs are 0; state is IDLE; wait counter is 0.
  - `last` = NUM_REQ-1, so requester 0 has first priority.
- `preset_n` asserted mid-transfer drops `psel_o` and `penable_o` immediately. The transfer is abandoned and no `done_o` is issued.

## Timing
- Request seen in IDLE at edge E: SETUP at E+1 (with `gnt_o`), ACCESS at E+2.
- With `pready_i` in the first ACCESS cycle: `done_o` at E+3.
- Against the test slave (`pready_i` one cycle late), ACCESS lasts 2 cycles. `done_o` is at E+4, and the next grant can enter SETUP at E+5.
- Minimum transfer period is 3 cycles.
- Simultaneous requests never produce more than one `gnt_o` bit.
- A requester that keeps requesting waits at most NUM_REQ-1 other transfers.

## Structure
- Package `apb_arb_pkg` holds:
  - the `apb_arb_state_e` enum {IDLE, SETUP, ACCESS};
  - default width constants ADDR_W and DATA_W.
- Sub-module `apb_rr_pick`: combinational round-robin pick. Inputs are the `req` vector and `last`; outputs are a one-hot `gnt` and the index. Instantiated once.
- The top level holds the FSM, capture registers, wait counter and `rdata_o`.

## Test plan
- **Reset:** `preset_n`=0 for 2 cycles.
  - All outputs are 0.
  - After release, `psel_o`=0 until a request arrives.
- **Single read:** `req_i`=4'b0010, addr 0x10, slave returns 0x1A.
  - `gnt_o`=4'b0010 in SETUP, `paddr_o`=0x10, `pwrite_o`=0.
  - Then `done_o`=4'b0010, `rdata_o`=0x1A, `err_o`=0.
- **Single write:** req 2, addr 0x20, wdata 0xDEADBEEF.
  - `pwrite_o`=1.
  - `pwdata_o`=0xDEADBEEF stable through ACCESS.
  - `done_o`=4'b0100, `rdata_o` unchanged.
- **Contention:** all four `req_i` held, each requester re-requesting after `done_o`.
  - Grant order is 0, 1, 2, 3, 0.
  - Exactly one `gnt_o` bit per SETUP.
- **Timeout:** `pready_i` held at 0, `TIMEOUT`=16, read.
  - After 16 ACCESS cycles: `done_o` pulse with `err_o`=1.
  - `rdata_o`=0, `psel_o`=0.
- **Mid-transfer reset:** `preset_n`=0 during ACCESS of requester 3.
  - `psel_o` and `penable_o` are 0 immediately; no `done_o`.
  - After release with req 0 and req 3 both held, req 0 is granted first.
